// File: rtl/prog_loader.sv
// Program-memory loader: parses a framed byte stream into 17-bit instruction words,
// writes them sequentially and holds the CPU pipeline in reset while a frame is loading.
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 17,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMO_W = 24;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SYNC  = 4'd1,
        S_COUNT = 4'd2,
        S_B0    = 4'd3,
        S_B1    = 4'd4,
        S_B2    = 4'd5,
        S_WRITE = 4'd6,
        S_CSUM  = 4'd7,
        S_DONE  = 4'd8,
        S_ERR   = 4'd9
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              accept;
    logic              counting;
    logic              timed_out;
    logic              last_word;
    logic [CNT_W-1:0]  n_full;

    logic [7:0]        sum_q;
    logic [7:0]        sum_nxt;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] n_nxt;
    logic              b0_q;
    logic              b0_nxt;
    logic [7:0]        b1_q;
    logic [7:0]        b1_nxt;
    logic [TMO_W-1:0]  idle_q;
    logic [TMO_W-1:0]  idle_nxt;

    logic              rx_ready_nxt;
    logic              prog_we_nxt;
    logic              cpu_hold_nxt;
    logic              done_nxt;
    logic              error_nxt;
    logic [ADDR_W-1:0] prog_addr_nxt;
    logic [DATA_W-1:0] prog_data_nxt;
    logic [CNT_W-1:0]  word_count_nxt;

    assign accept    = rx_valid & rx_ready;
    assign counting  = state inside {S_COUNT, S_B0, S_B1, S_B2, S_CSUM};
    assign timed_out = counting && !accept && (idle_q == TIMEOUT - TMO_W'(1));
    // A word count of zero encodes a full memory image.
    assign n_full    = (n_q == '0) ? {1'b1, {ADDR_W{1'b0}}} : CNT_W'(n_q);
    assign last_word = (word_count + CNT_W'(1)) == n_full;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) state_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (accept && rx_data == SYNC_BYTE) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (accept)         state_nxt = S_B0;
                else if (timed_out) state_nxt = S_ERR;
            end
            S_B0: begin
                if (accept)         state_nxt = (rx_data[7:1] == 7'd0) ? S_B1 : S_ERR;
                else if (timed_out) state_nxt = S_ERR;
            end
            S_B1: begin
                if (accept)         state_nxt = S_B2;
                else if (timed_out) state_nxt = S_ERR;
            end
            S_B2: begin
                if (accept)         state_nxt = S_WRITE;
                else if (timed_out) state_nxt = S_ERR;
            end
            S_WRITE: begin
                state_nxt = last_word ? S_CSUM : S_B0;
            end
            S_CSUM: begin
                if (accept)         state_nxt = (rx_data == sum_q) ? S_DONE : S_ERR;
                else if (timed_out) state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; flags decode the upcoming state so they register cleanly
    always_comb begin
        rx_ready_nxt   = state_nxt inside {S_SYNC, S_COUNT, S_B0, S_B1, S_B2, S_CSUM};
        cpu_hold_nxt   = state_nxt inside {S_SYNC, S_COUNT, S_B0, S_B1, S_B2, S_WRITE, S_CSUM};
        prog_we_nxt    = (state_nxt == S_WRITE);
        done_nxt       = (state_nxt == S_DONE);
        error_nxt      = (state_nxt == S_ERR);
        prog_addr_nxt  = prog_addr;
        prog_data_nxt  = prog_data;
        word_count_nxt = word_count;
        sum_nxt        = sum_q;
        n_nxt          = n_q;
        b0_nxt         = b0_q;
        b1_nxt         = b1_q;
        idle_nxt       = (counting && !accept) ? idle_q + TMO_W'(1) : '0;

        if (state_nxt == S_SYNC && state != S_SYNC) begin
            prog_addr_nxt  = '0;
            word_count_nxt = '0;
            sum_nxt        = '0;
        end

        case (state)
            S_COUNT: begin
                if (accept) begin
                    n_nxt   = ADDR_W'(rx_data);
                    sum_nxt = rx_data;
                end
            end
            S_B0: begin
                if (accept) begin
                    b0_nxt  = rx_data[0];
                    sum_nxt = sum_q + rx_data;
                end
            end
            S_B1: begin
                if (accept) begin
                    b1_nxt  = rx_data;
                    sum_nxt = sum_q + rx_data;
                end
            end
            S_B2: begin
                if (accept) begin
                    prog_data_nxt = DATA_W'({b0_q, b1_q, rx_data});
                    sum_nxt       = sum_q + rx_data;
                end
            end
            S_WRITE: begin
                prog_addr_nxt  = prog_addr + ADDR_W'(1);
                word_count_nxt = word_count + CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ready   <= 1'b0;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            sum_q      <= '0;
            n_q        <= '0;
            b0_q       <= 1'b0;
            b1_q       <= '0;
            idle_q     <= '0;
        end else begin
            rx_ready   <= rx_ready_nxt;
            prog_we    <= prog_we_nxt;
            prog_addr  <= prog_addr_nxt;
            prog_data  <= prog_data_nxt;
            cpu_hold   <= cpu_hold_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            word_count <= word_count_nxt;
            sum_q      <= sum_nxt;
            n_q        <= n_nxt;
            b0_q       <= b0_nxt;
            b1_q       <= b1_nxt;
            idle_q     <= idle_nxt;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle-accurate vector table plus frame-level sequences
// covering gaps, junk bytes, bad checksum/format, timeout, full-memory wrap and mid-frame reset.
module tb_prog_loader;
    localparam int TB_TMO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [16:0] prog_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    int tests = 0;
    int fails = 0;
    logic [7:0] csum;
    logic [7:0]  wr_addr[$];
    logic [16:0] wr_data[$];

    prog_loader #(.TIMEOUT(24'(TB_TMO))) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .cpu_hold(cpu_hold),
        .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every write strobe away from the active edge
    always @(negedge clk) begin
        if (prog_we) begin
            wr_addr.push_back(prog_addr);
            wr_data.push_back(prog_data);
        end
    end

    typedef struct packed {
        logic        ld;
        logic        vl;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [16:0] data;
        logic        hold;
        logic        dn;
        logic        er;
        logic [8:0]  wc;
    } vec_t;

    vec_t vecs [0:15];

    function automatic vec_t mk(input logic ld, input logic vl, input logic [7:0] d,
                                input logic rdy, input logic we, input logic [7:0] addr,
                                input logic [16:0] data, input logic hold, input logic dn,
                                input logic er, input logic [8:0] wc);
        vec_t r;
        r = {ld, vl, d, rdy, we, addr, data, hold, dn, er, wc};
        return r;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({rx_ready, prog_we, prog_addr, prog_data, cpu_hold, done, error, word_count});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic start_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Offer one byte after an optional idle gap; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        if (rx_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL rx_ready wait: got %0b, expected 1 within 64 cycles", rx_ready);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [16:0] w, input int gap);
        logic [7:0] b0;
        b0 = {7'd0, w[16]};
        send_byte(b0, gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
        csum = csum + b0 + w[15:8] + w[7:0];
        check("we one cycle after B2", 64'(prog_we), 64'd1);
    endtask

    initial begin
        int base;
        int bad;
        logic [7:0]  iv;
        logic [16:0] w;
        logic [16:0] exp3 [0:2];

        do_reset();
        check("reset outputs", outs(), 64'd0);

        // Idle junk (no load_req) then a single-word frame, cycle by cycle
        vecs[0]  = mk(0, 1, 8'hA5, 0, 0, 8'd0, 17'h0, 0, 0, 0, 9'd0);
        vecs[1]  = mk(0, 1, 8'h01, 0, 0, 8'd0, 17'h0, 0, 0, 0, 9'd0);
        vecs[2]  = mk(0, 1, 8'h01, 0, 0, 8'd0, 17'h0, 0, 0, 0, 9'd0);
        vecs[3]  = mk(0, 1, 8'hFF, 0, 0, 8'd0, 17'h0, 0, 0, 0, 9'd0);
        vecs[4]  = mk(0, 1, 8'hFF, 0, 0, 8'd0, 17'h0, 0, 0, 0, 9'd0);
        vecs[5]  = mk(0, 1, 8'h00, 0, 0, 8'd0, 17'h0, 0, 0, 0, 9'd0);
        vecs[6]  = mk(1, 0, 8'h00, 1, 0, 8'd0, 17'h0, 1, 0, 0, 9'd0);
        vecs[7]  = mk(0, 1, 8'hA5, 1, 0, 8'd0, 17'h0, 1, 0, 0, 9'd0);
        vecs[8]  = mk(0, 1, 8'h01, 1, 0, 8'd0, 17'h0, 1, 0, 0, 9'd0);
        vecs[9]  = mk(1, 1, 8'h01, 1, 0, 8'd0, 17'h0, 1, 0, 0, 9'd0);
        vecs[10] = mk(0, 1, 8'h23, 1, 0, 8'd0, 17'h0, 1, 0, 0, 9'd0);
        vecs[11] = mk(0, 1, 8'h45, 0, 1, 8'd0, 17'h12345, 1, 0, 0, 9'd0);
        vecs[12] = mk(0, 1, 8'h6A, 1, 0, 8'd1, 17'h12345, 1, 0, 0, 9'd1);
        vecs[13] = mk(0, 1, 8'h6A, 0, 0, 8'd1, 17'h12345, 0, 1, 0, 9'd1);
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 8'd1, 17'h12345, 0, 1, 0, 9'd1);
        vecs[15] = mk(1, 0, 8'h00, 1, 0, 8'd0, 17'h12345, 1, 0, 0, 9'd0);

        for (int i = 0; i < 16; i++) begin
            load_req = vecs[i].ld;
            rx_valid = vecs[i].vl;
            rx_data  = vecs[i].d;
            tick();
            check($sformatf("vector %0d", i), outs(),
                  64'({vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].data,
                       vecs[i].hold, vecs[i].dn, vecs[i].er, vecs[i].wc}));
        end

        // Three words with gaps and leading junk
        do_reset();
        start_load();
        base = wr_addr.size();
        send_byte(8'h00, 0);
        send_byte(8'h5A, 1);
        send_byte(8'hA5, 0);
        send_byte(8'h03, 2);
        csum = 8'h03;
        exp3[0] = 17'h00001;
        exp3[1] = 17'h1ABCD;
        exp3[2] = 17'h0FFFF;
        send_word(exp3[0], 1);
        send_word(exp3[1], 2);
        send_word(exp3[2], 0);
        send_byte(csum, 1);
        check("3w done", 64'({done, error, cpu_hold}), 64'b100);
        check("3w word_count", 64'(word_count), 64'd3);
        check("3w write count", 64'(wr_addr.size() - base), 64'd3);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("3w addr %0d", j), 64'(wr_addr[base+j]), 64'(j));
            check($sformatf("3w data %0d", j), 64'(wr_data[base+j]), 64'(exp3[j]));
        end

        // Checksum off by one: words land, frame flagged
        do_reset();
        start_load();
        base = wr_addr.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        csum = 8'h02;
        send_word(17'h05555, 0);
        send_word(17'h10001, 1);
        send_byte(csum + 8'd1, 0);
        check("bad csum flags", 64'({done, error, cpu_hold}), 64'b010);
        check("bad csum writes", 64'(wr_addr.size() - base), 64'd2);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        repeat (3) tick();
        check("err holds off bytes", 64'(rx_ready), 64'd0);
        rx_valid = 1'b0;

        // Bad B0 format aborts before that word is written
        do_reset();
        start_load();
        base = wr_addr.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        csum = 8'h02;
        send_word(17'h00ABC, 0);
        send_byte(8'h02, 0);
        check("bad b0 flags", 64'({done, error, cpu_hold, rx_ready}), 64'b0100);
        tick();
        check("bad b0 writes", 64'(wr_addr.size() - base), 64'd1);

        // Stall after B1 until the idle timeout fires
        do_reset();
        start_load();
        base = wr_addr.size();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        repeat (TB_TMO - 1) tick();
        check("timeout not yet", 64'(error), 64'd0);
        tick();
        check("timeout error", 64'({done, error, cpu_hold}), 64'b010);
        check("timeout no write", 64'(wr_addr.size() - base), 64'd0);

        // N=0 loads all 256 words and wraps the address
        do_reset();
        start_load();
        base = wr_addr.size();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        csum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            send_word({iv[0], iv, ~iv}, 0);
        end
        send_byte(csum, 0);
        check("full done", 64'({done, error, cpu_hold}), 64'b100);
        check("full word_count", 64'(word_count), 64'd256);
        check("full addr wrap", 64'(prog_addr), 64'd0);
        check("full write count", 64'(wr_addr.size() - base), 64'd256);
        bad = 0;
        for (int i = 0; i < 256 && base + i < wr_addr.size(); i++) begin
            iv = 8'(i);
            w  = {iv[0], iv, ~iv};
            if (wr_addr[base+i] !== iv || wr_data[base+i] !== w) bad++;
        end
        check("full write contents", 64'(bad), 64'd0);

        // Reset mid-frame clears outputs and stops further writes
        do_reset();
        start_load();
        base = wr_addr.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        csum = 8'h02;
        send_word(17'h11122, 0);
        send_byte(8'h01, 0);
        reset = 1'b1;
        tick();
        check("mid-frame reset", outs(), 64'd0);
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        repeat (4) tick();
        rx_valid = 1'b0;
        check("post reset idle", 64'({rx_ready, cpu_hold}), 64'd0);
        check("post reset writes", 64'(wr_addr.size() - base), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
